mem_arbiter: RTL

- Two-requester arbiter and access sequencer for the single-port 4096x16 main memory.
- Port 0 serves the CPU fetch/execute path. Port 1 serves the DMA/program loader.
- Arbitrates between the two, drives the memory's write_enable/write_data/memory_address, captures read data and returns a one-cycle ack to the winner.
- Sits between both masters and the memory unit. It is the only block that drives memory inputs.

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for a single-port synchronous-write memory.
// Each granted request takes three cycles: IDLE (arbitrate), ACCESS (drive memory), DONE (ack).
module mem_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter bit RR_MODE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_reg, state_next;
  logic                owner_reg;
  logic                last_owner_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rdata_reg [2];
  logic                winner;

  // Ties go to the port that was not served last (round-robin) or always to port 0.
  always_comb begin
    winner = 1'b0;
    if (p0_req && p1_req) begin
      winner = RR_MODE ? ~last_owner_reg : 1'b0;
    end else if (p1_req) begin
      winner = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (p0_req || p1_req) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      if (state_reg == IDLE && (p0_req || p1_req)) begin
        owner_reg <= winner;
        we_reg    <= winner ? p1_we    : p0_we;
        addr_reg  <= winner ? p1_addr  : p0_addr;
        wdata_reg <= winner ? p1_wdata : p0_wdata;
      end
      if (state_reg == ACCESS) begin
        last_owner_reg <= owner_reg;
      end
    end
  end

  // Only the owning port's read register captures, and only on a read access.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_reg[gi] <= '0;
        end else if (state_reg == ACCESS && !we_reg && owner_reg == 1'(gi)) begin
          rdata_reg[gi] <= mem_read_data;
        end
      end
    end
  endgenerate

  always_comb begin
    p0_ack           = (state_reg == DONE) && !owner_reg;
    p1_ack           = (state_reg == DONE) &&  owner_reg;
    busy             = (state_reg != IDLE);
    // Gated by rst_n so an in-flight write is cut off the moment reset asserts.
    mem_write_enable = rst_n && (state_reg == ACCESS) && we_reg;
    mem_address      = addr_reg;
    mem_write_data   = wdata_reg;
    p0_rdata         = rdata_reg[0];
    p1_rdata         = rdata_reg[1];
  end

endmodule
